// File: rtl/data_mem_pkg.sv
// data_mem_pkg: access-size encodings, FSM states and latency counter width for data_mem_ls
package data_mem_pkg;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;
  localparam int CNT_W = 4;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_BAD || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/data_mem_bank.sv
// data_mem_bank: word-organised byte storage with per-lane write enables and a registered read port
module data_mem_bank #(
  parameter int DEPTH = 256,
  parameter int ADDR_W = 8,
  parameter logic [7:0] INIT_BYTE = 8'h03
) (
  input  logic              clk,
  input  logic [ADDR_W-3:0] raddr,
  output logic [31:0]       rdata,
  input  logic [ADDR_W-3:0] waddr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata
);
  logic [7:0] mem [DEPTH] = '{default: INIT_BYTE};
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (we[l]) mem[{waddr, 2'(l)}] <= wdata[8*l +: 8];
      rdata[8*l +: 8] <= mem[{raddr, 2'(l)}];
    end
  end
endmodule

// File: rtl/data_mem_ls.sv
// data_mem_ls: fixed-latency load/store unit over a byte-addressed little-endian data memory
module data_mem_ls
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter int ADDR_W = 8,
  parameter int LATENCY = 1,
  parameter logic [7:0] INIT_BYTE = 8'h03
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Req,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Done,
  output logic              Busy,
  output logic              AlignErr
);
  state_e state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] size_q;
  logic uns_q, rd_q, wr_q, err_q;
  logic [31:0] wd_q, rdata_q, bank_rd, load_val, lane_data;
  logic [3:0] lane_we;
  logic [ADDR_W-3:0] rd_word;
  logic accept, load_ok, store_ok;
  assign accept = state == S_IDLE && Req && (MemRead || MemWrite);
  assign Done = state == S_RESP;
  assign Busy = state != S_IDLE;
  assign AlignErr = Done & err_q;
  assign load_ok = Done & rd_q & ~err_q;
  assign store_ok = Done & wr_q & ~err_q;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    case (state)
      S_IDLE: if (accept) begin
        state_d = LATENCY == 1 ? S_RESP : S_WAIT;
        cnt_d = CNT_W'(LATENCY - 1);
      end
      S_WAIT: begin
        cnt_d = cnt - 1'b1;
        state_d = cnt == CNT_W'(1) ? S_RESP : S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      if (load_ok) rdata_q <= load_val;
    end
    if (accept) begin
      addr_q <= Address;
      size_q <= Size;
      uns_q <= Unsigned;
      rd_q <= MemRead;
      wr_q <= MemWrite;
      wd_q <= 32'(WriteData);
      err_q <= misaligned(Size, Address[1:0]);
    end
  end
  // Reading at the accepting edge lets a one-cycle access have its word ready in RESP
  assign rd_word = state == S_IDLE ? Address[ADDR_W-1:2] : addr_q[ADDR_W-1:2];
  assign lane_we = size_q == SZ_BYTE ? 4'b0001 << addr_q[1:0] :
                   size_q == SZ_HALF ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign lane_data = size_q == SZ_BYTE ? {4{wd_q[7:0]}} :
                     size_q == SZ_HALF ? {2{wd_q[15:0]}} : wd_q;
  assign load_val = size_q == SZ_BYTE ?
                      {{24{bank_rd[{addr_q[1:0], 3'b111}] & ~uns_q}}, bank_rd[{addr_q[1:0], 3'b000} +: 8]} :
                    size_q == SZ_HALF ?
                      {{16{bank_rd[{addr_q[1], 4'b1111}] & ~uns_q}}, bank_rd[{addr_q[1], 4'b0000} +: 16]} :
                      bank_rd;
  assign ReadData = DATA_W'(load_ok ? load_val : rdata_q);
  data_mem_bank #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .INIT_BYTE(INIT_BYTE)
  ) u_bank (
    .clk(clk),
    .raddr(rd_word),
    .rdata(bank_rd),
    .waddr(addr_q[ADDR_W-1:2]),
    .we(store_ok ? lane_we : 4'b0000),
    .wdata(lane_data)
  );
endmodule

// File: doc/data_mem_ls.md
DATA_MEM_LS -- requirements
Module: data_mem_ls

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits, fixed multiple of 8, max 32.
REQ-002 SHALL have parameter DEPTH, default 256, memory size in bytes, power of two, multiple of 4.
REQ-003 SHALL have parameter ADDR_W, default 8, byte address width, equal to log2(DEPTH).
REQ-004 SHALL have parameter LATENCY, default 1, cycles from request acceptance to Done, range 1..15.
REQ-005 SHALL have parameter INIT_BYTE, default 8'h03, power-up value of every byte.
REQ-006 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset; the design has one clock, and reset is synchronous and active-high.
REQ-007 SHALL have ports: Req  in  1  request strobe; MemRead  in  1  load; MemWrite  in  1  store.
REQ-008 SHALL have ports: Size  in  2  00 byte, 01 half, 10 word, 11 illegal; Unsigned  in  1  zero-extend loads.
REQ-009 SHALL have ports: Address  in  ADDR_W  byte address; WriteData  in  DATA_W  store data, LSB-aligned.
REQ-010 SHALL have ports: ReadData  out  DATA_W  load result; Done  out  1  one-cycle completion pulse; Busy  out  1  request in flight; AlignErr  out  1  error flag, valid with Done.

Function
REQ-011 SHALL use little-endian byte ordering: byte at Address maps to bits [7:0].
REQ-012 SHALL accept a request on a rising edge where the FSM is IDLE, Req=1, and (MemRead|MemWrite)=1; Req with neither bit set SHALL be ignored.
REQ-013 SHALL capture Address, Size, Unsigned, WriteData and command at acceptance; input changes while Busy SHALL be ignored.
REQ-014 SHALL ignore Req while Busy=1, with no queuing.
REQ-015 SHALL implement FSM states IDLE -> WAIT (LATENCY-1 cycles, down-counter) -> RESP -> IDLE; when LATENCY=1, the FSM SHALL go IDLE -> RESP directly.
REQ-016 SHALL assert Busy in WAIT and RESP, and SHALL assert Done only in RESP, exactly LATENCY cycles after the accepting edge.
REQ-017 SHALL flag misalignment: half with Address[0]=1, word with Address[1:0]!=0, or Size=11 -> AlignErr=1 with Done, no memory read or write, ReadData unchanged.
REQ-018 SHALL perform loads at the RESP edge: byte/half sign-extended from bit 7/15 unless Unsigned=1, then zero-extended; word loads SHALL ignore Unsigned.
REQ-019 SHALL hold ReadData until the next successful load completes.
REQ-020 SHALL perform stores at the RESP edge, writing only the addressed lanes: byte 1, half 2, word 4, taken from WriteData LSBs.
REQ-021 SHALL, when MemRead and MemWrite are both set, return the pre-write data on ReadData (read-before-write) and then commit the write.
REQ-022 SHALL NOT wrap accesses past DEPTH-1, since alignment rules guarantee this.
REQ-023 SHALL hold AlignErr=0 whenever Done=0.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, set FSM to IDLE, counter to 0, Busy=0, Done=0, AlignErr=0, and ReadData=0.
REQ-025 SHALL abort any in-flight request on reset, with no write and no Done.
REQ-026 SHALL NOT alter memory contents on reset; contents SHALL equal INIT_BYTE only at time zero.
REQ-027 SHALL give reset priority over Req in the same cycle.

Structure
REQ-028 SHALL place the Size encodings, FSM state encoding and the latency-counter width constant in shared package data_mem_pkg.
REQ-029 SHALL place the byte storage in one sub-module, data_mem_bank, with 4 byte-lane write enables and a synchronous read port; FSM, alignment check and extension logic SHALL reside in data_mem_ls.

Verification
REQ-030 SHALL cover: word store 32'hDEADBEEF at addr 0x10, then word load at 0x10 -> ReadData=32'hDEADBEEF, Done exactly LATENCY cycles after each accept.
REQ-031 SHALL cover: byte load at 0x13 signed -> 32'hFFFFFFDE; same access with Unsigned=1 -> 32'h000000DE; half load at 0x10 signed -> 32'hFFFFBEEF.
REQ-032 SHALL cover: half store 16'h1234 at 0x21 -> AlignErr=1 with Done, and a word load at 0x20 -> 32'h03030303 (memory untouched).
REQ-033 SHALL cover: LATENCY=3, second Req during Busy -> ignored, exactly one Done, Busy high for 3 cycles.
REQ-034 SHALL cover: reset asserted one cycle after a word store accept (LATENCY=3) -> no Done, and a later load of that address returns the prior contents.
REQ-035 SHALL cover: MemRead=MemWrite=1 word at 0x30 holding 32'h03030303 with WriteData=32'hA5A5A5A5 -> ReadData=32'h03030303, then a load returns 32'hA5A5A5A5.
